// File: rtl/arc4_pkg.sv
// Shared types and sizes for the ARC4 sequencer and its S-memory arbiter.
package arc4_pkg;

    localparam int KEY_W  = 24;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INIT_GO   = 3'd1,
        INIT_WAIT = 3'd2,
        KSA_GO    = 3'd3,
        KSA_WAIT  = 3'd4,
        PRGA_GO   = 3'd5,
        PRGA_WAIT = 3'd6
    } sched_state_t;

    typedef enum logic [1:0] {
        PH_NONE = 2'd0,
        PH_INIT = 2'd1,
        PH_KSA  = 2'd2,
        PH_PRGA = 2'd3
    } phase_t;

    function automatic phase_t phase_of(input sched_state_t st);
        phase_t ph;
        case (st)
            INIT_GO, INIT_WAIT: ph = PH_INIT;
            KSA_GO,  KSA_WAIT:  ph = PH_KSA;
            PRGA_GO, PRGA_WAIT: ph = PH_PRGA;
            default:            ph = PH_NONE;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/arc4_sched_s_mem_mux.sv
// Static S-memory arbiter: forwards the owning engine's port and flags any write
// attempted by an engine that does not own the memory in the current phase.
module s_mem_mux
    import arc4_pkg::*;
(
    input  phase_t              phase,
    input  logic [ADDR_W-1:0]   init_addr,
    input  logic [DATA_W-1:0]   init_wrdata,
    input  logic                init_wren,
    input  logic [ADDR_W-1:0]   ksa_addr,
    input  logic [DATA_W-1:0]   ksa_wrdata,
    input  logic                ksa_wren,
    input  logic [ADDR_W-1:0]   prga_addr,
    input  logic [DATA_W-1:0]   prga_wrdata,
    input  logic                prga_wren,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wrdata,
    output logic                s_wren,
    output logic                viol
);

    // Owner select; in PH_NONE every requester is a non-owner.
    always_comb begin
        s_addr   = {ADDR_W{1'b0}};
        s_wrdata = {DATA_W{1'b0}};
        s_wren   = 1'b0;
        viol     = 1'b0;
        case (phase)
            PH_INIT: begin
                s_addr   = init_addr;
                s_wrdata = init_wrdata;
                s_wren   = init_wren;
                viol     = ksa_wren | prga_wren;
            end
            PH_KSA: begin
                s_addr   = ksa_addr;
                s_wrdata = ksa_wrdata;
                s_wren   = ksa_wren;
                viol     = init_wren | prga_wren;
            end
            PH_PRGA: begin
                s_addr   = prga_addr;
                s_wrdata = prga_wrdata;
                s_wren   = prga_wren;
                viol     = init_wren | ksa_wren;
            end
            default: begin
                viol     = init_wren | ksa_wren | prga_wren;
            end
        endcase
    end

endmodule

// File: rtl/arc4_sched.sv
// ARC4 decrypt sequencer: latches a key, runs init -> ksa -> prga through their
// en/rdy handshakes and hands the S memory to whichever phase is active.
module arc4_sched
    import arc4_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    output logic                rdy,
    input  logic [KEY_W-1:0]    key,
    output logic [KEY_W-1:0]    key_q,
    output logic                done,
    output logic                err,
    output logic [CNT_W-1:0]    cyc_count,
    output logic                init_en,
    output logic                ksa_en,
    output logic                prga_en,
    input  logic                init_rdy,
    input  logic                ksa_rdy,
    input  logic                prga_rdy,
    input  logic [ADDR_W-1:0]   init_addr,
    input  logic [ADDR_W-1:0]   ksa_addr,
    input  logic [ADDR_W-1:0]   prga_addr,
    input  logic [DATA_W-1:0]   init_wrdata,
    input  logic [DATA_W-1:0]   ksa_wrdata,
    input  logic [DATA_W-1:0]   prga_wrdata,
    input  logic                init_wren,
    input  logic                ksa_wren,
    input  logic                prga_wren,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wrdata,
    output logic                s_wren
);

    sched_state_t           r_state;
    logic                   r_done;
    logic                   r_err;
    logic [CNT_W-1:0]       r_cyc;
    logic [KEY_W-1:0]       r_key;
    logic                   w_viol;
    logic                   w_accept;

    assign w_accept  = (r_state == IDLE) && en;
    assign rdy       = (r_state == IDLE);
    assign init_en   = (r_state == INIT_GO) && init_rdy;
    assign ksa_en    = (r_state == KSA_GO)  && ksa_rdy;
    assign prga_en   = (r_state == PRGA_GO) && prga_rdy;
    assign done      = r_done;
    assign err       = r_err;
    assign cyc_count = r_cyc;
    assign key_q     = r_key;

    s_mem_mux u_mux (
        .phase       (phase_of(r_state)),
        .init_addr   (init_addr),
        .init_wrdata (init_wrdata),
        .init_wren   (init_wren),
        .ksa_addr    (ksa_addr),
        .ksa_wrdata  (ksa_wrdata),
        .ksa_wren    (ksa_wren),
        .prga_addr   (prga_addr),
        .prga_wrdata (prga_wrdata),
        .prga_wren   (prga_wren),
        .s_addr      (s_addr),
        .s_wrdata    (s_wrdata),
        .s_wren      (s_wren),
        .viol        (w_viol)
    );

    // Phase sequencer with key latch, busy-cycle counter, done pulse and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_cyc   <= {CNT_W{1'b0}};
            r_key   <= {KEY_W{1'b0}};
        end else begin
            r_done <= 1'b0;
            // Accept outranks a same-cycle violation so a new run starts clean.
            if (w_accept) begin
                r_err <= 1'b0;
            end else if (w_viol) begin
                r_err <= 1'b1;
            end
            if ((r_state != IDLE) && (r_cyc != {CNT_W{1'b1}})) begin
                r_cyc <= r_cyc + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            case (r_state)
                IDLE: begin
                    if (en) begin
                        r_key   <= key;
                        r_cyc   <= {CNT_W{1'b0}};
                        r_state <= INIT_GO;
                    end
                end
                INIT_GO:   if (init_rdy) r_state <= INIT_WAIT;
                INIT_WAIT: if (init_rdy) r_state <= KSA_GO;
                KSA_GO:    if (ksa_rdy)  r_state <= KSA_WAIT;
                KSA_WAIT:  if (ksa_rdy)  r_state <= PRGA_GO;
                PRGA_GO:   if (prga_rdy) r_state <= PRGA_WAIT;
                PRGA_WAIT: begin
                    if (prga_rdy) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default:   r_state <= IDLE;
            endcase
        end
    end

endmodule
